// File: rtl/comparator3_sequencer.sv
// comparator3_sequencer
//   Multi-cycle magnitude compare of two WIDTH-bit operands using one shared,
//   external 3-bit comparator3 slice. Chunks are processed LSB first; each
//   slice reply {lt,et,gt} becomes the cascade input {l,e,g} of the next chunk.
//
//   Parameters:
//     WIDTH  operand width, a multiple of 3 and >= 3 (elaboration error otherwise)
//
//   Configuration macro:
//     SIGNED_COMPARE_EN  when defined, operands are two's complement: bit 2 of
//                        both slice operands is inverted on the last chunk.
//
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     start, op_a, op_b         request and operands (sampled only in IDLE)
//     busy, done                running flag, one-cycle result-valid pulse
//     lt, eq, gt, err           result flags and non-one-hot slice reply flag
//     cmp_a, cmp_b              chunk operands driven to the slice
//     cmp_l, cmp_e, cmp_g       cascade inputs driven to the slice
//     cmp_lt, cmp_et, cmp_gt    same-cycle slice reply
module comparator3_sequencer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             err,
  output logic [2:0]       cmp_a,
  output logic [2:0]       cmp_b,
  output logic             cmp_l,
  output logic             cmp_e,
  output logic             cmp_g,
  input  logic             cmp_lt,
  input  logic             cmp_et,
  input  logic             cmp_gt
);

  localparam int unsigned CHUNKS = WIDTH / 3;
  localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHUNKS - 1);
  localparam logic [2:0]       CASC_INIT = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reject operand widths that do not split into whole 3-bit chunks
  generate
    if (((WIDTH % 3) != 0) || (WIDTH < 3)) begin : g_bad_width
      $error("comparator3_sequencer: WIDTH must be a multiple of 3 and >= 3");
    end
  endgenerate

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       casc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             accept_c;
  logic             last_c;
  logic [2:0]       reply_c;
  logic             reply_onehot_c;

  logic [IDX_W-1:0] drv_idx_c;
  logic [WIDTH-1:0] a_shift_c;
  logic [WIDTH-1:0] b_shift_c;
  logic [2:0]       chunk_a_c;
  logic [2:0]       chunk_b_c;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = (idx_q == LAST_IDX);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          accept_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Slice reply classification
  always_comb begin
    reply_c        = {cmp_lt, cmp_et, cmp_gt};
    reply_onehot_c = (reply_c == 3'b100) || (reply_c == 3'b010) || (reply_c == 3'b001);
  end

  // Slice drive: outside RUN the slice sees chunk 0 with a neutral cascade
  always_comb begin
    drv_idx_c = (state_q == ST_RUN) ? idx_q : '0;
    a_shift_c = a_q >> (3 * drv_idx_c);
    b_shift_c = b_q >> (3 * drv_idx_c);
    chunk_a_c = a_shift_c[2:0];
    chunk_b_c = b_shift_c[2:0];
`ifdef SIGNED_COMPARE_EN
    // Sign-offset mapping: flipping the sign bit turns a signed compare of
    // the top chunk into an unsigned one.
    if ((state_q == ST_RUN) && (idx_q == LAST_IDX)) begin
      chunk_a_c[2] = ~chunk_a_c[2];
      chunk_b_c[2] = ~chunk_b_c[2];
    end
`else
    chunk_a_c = chunk_a_c;
    chunk_b_c = chunk_b_c;
`endif
  end

  assign cmp_a = chunk_a_c;
  assign cmp_b = chunk_b_c;
  assign cmp_l = (state_q == ST_RUN) ? casc_q[2] : CASC_INIT[2];
  assign cmp_e = (state_q == ST_RUN) ? casc_q[1] : CASC_INIT[1];
  assign cmp_g = (state_q == ST_RUN) ? casc_q[0] : CASC_INIT[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      casc_q <= CASC_INIT;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      err    <= 1'b0;
    end else begin
      busy <= (state_d == ST_RUN);
      done <= (state_d == ST_DONE);
      if (accept_c) begin
        a_q    <= op_a;
        b_q    <= op_b;
        idx_q  <= '0;
        casc_q <= CASC_INIT;
        err    <= 1'b0;
      end else if (state_q == ST_RUN) begin
        casc_q <= reply_c;
        idx_q  <= last_c ? '0 : idx_q + IDX_W'(1);
        if (!reply_onehot_c) begin
          err <= 1'b1;
        end
        // Final slice reply is the overall result
        if (last_c) begin
          lt <= cmp_lt;
          eq <= cmp_et;
          gt <= cmp_gt;
        end
      end
    end
  end

endmodule

// File: tb/tb_comparator3_sequencer.sv
// Bench for comparator3_sequencer (WIDTH=12): behavioural comparator3 slice,
// arithmetic reference model, scoreboard queue and a decoupled monitor.
module tb_comparator3_sequencer;

  localparam int unsigned WIDTH  = 12;
  localparam int          CHUNKS = WIDTH / 3;

  typedef struct {
    logic [2:0] res;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy, done, lt, eq, gt, err;
  logic [2:0]       cmp_a, cmp_b;
  logic             cmp_l, cmp_e, cmp_g;
  logic             cmp_lt, cmp_et, cmp_gt;

  comparator3_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .err(err),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g),
    .cmp_lt(cmp_lt), .cmp_et(cmp_et), .cmp_gt(cmp_gt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   busy_cnt = 0;
  logic fault_en = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    busy_cnt <= busy ? busy_cnt + 1 : 0;
  end

  // Behavioural comparator3 slice; optional fault on the third RUN cycle
  always_comb begin
    if (cmp_a < cmp_b)      {cmp_lt, cmp_et, cmp_gt} = 3'b100;
    else if (cmp_a > cmp_b) {cmp_lt, cmp_et, cmp_gt} = 3'b001;
    else                    {cmp_lt, cmp_et, cmp_gt} = {cmp_l, cmp_e, cmp_g};
    if (fault_en && busy && (busy_cnt == 2)) {cmp_lt, cmp_et, cmp_gt} = 3'b101;
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [2:0] held = 3'b000;
  logic have_last = 1'b0;
  logic mon_en = 1'b0;
  int   last_e = 0;
  int   next_ok = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Whole-word reference compare
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SIGNED_COMPARE_EN
    if ($signed(a) < $signed(b)) return 3'b100;
    if ($signed(a) > $signed(b)) return 3'b001;
`else
    if (a < b) return 3'b100;
    if (a > b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Result when chunk 2 reply is forced to lt=gt=1: only the top chunk can override it
  function automatic logic [2:0] ref_fault(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2:0] ta, tb;
    ta = a[WIDTH-1 -: 3];
    tb = b[WIDTH-1 -: 3];
`ifdef SIGNED_COMPARE_EN
    if ($signed(ta) < $signed(tb)) return 3'b100;
    if ($signed(ta) > $signed(tb)) return 3'b001;
`else
    if (ta < tb) return 3'b100;
    if (ta > tb) return 3'b001;
`endif
    return 3'b101;
  endfunction

  // Drive one cycle; record an expectation when the request will be accepted
  task automatic drive(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    @(negedge clk);
    start = s;
    op_a  = a;
    op_b  = b;
    if (s && !rst && (cyc + 1 >= next_ok)) begin
      e.res = fault_en ? ref_fault(a, b) : ref_cmp(a, b);
      e.err = fault_en;
      q.push_back(e);
      last_e    = cyc + 1;
      have_last = 1'b1;
      next_ok   = cyc + 1 + CHUNKS + 2;
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    while (cyc + 1 < next_ok) drive(1'b0, 12'h0, 12'h0);
    drive(1'b1, a, b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_lt"},   32'(lt),   32'd0);
    check({tag, "_eq"},   32'(eq),   32'd0);
    check({tag, "_gt"},   32'(gt),   32'd0);
    check({tag, "_err"},  32'(err),  32'd0);
  endtask

  // Monitor: timing of busy/done, held result flags, scoreboard pop on done
  always @(posedge clk) begin
    exp_t e;
    logic exp_busy, exp_done;
    #1;
    if (mon_en && !rst) begin
      exp_busy = have_last && (cyc >= last_e) && (cyc < last_e + CHUNKS);
      exp_done = have_last && (cyc == last_e + CHUNKS);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (done) begin
        check("queue_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e    = q.pop_front();
          held = e.res;
          check("err_at_done", 32'(err), 32'(e.err));
        end
      end
      check("result_lt_eq_gt", 32'({lt, eq, gt}), 32'(held));
      if (have_last && (cyc == last_e)) check("err_cleared_on_start", 32'(err), 32'd0);
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    next_ok = cyc + 1;
    mon_en  = 1'b1;

    issue(12'h123, 12'h123);
    issue(12'h001, 12'h002);
    issue(12'h800, 12'h7FF);

    // Re-pulsed start during RUN must be ignored
    issue(12'h456, 12'h455);
    drive(1'b1, 12'h000, 12'h000);
    drive(1'b0, 12'h000, 12'h000);
    drive(1'b1, 12'h000, 12'hFFF);
    drive(1'b0, 12'h000, 12'h000);

    // Async reset in the second RUN cycle
    issue(12'h3A5, 12'h3A4);
    drive(1'b0, 12'h000, 12'h000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    q.delete();
    have_last = 1'b0;
    held      = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    next_ok = cyc + 1;
    issue(12'h000, 12'h000);

    // Faulty slice reply on chunk 2, then a clean request clears err
    while (cyc + 1 < next_ok) drive(1'b0, 12'h0, 12'h0);
    fault_en = 1'b1;
    drive(1'b1, 12'h0AB, 12'h0AB);
    repeat (CHUNKS + 2) drive(1'b0, 12'h000, 12'h000);
    fault_en = 1'b0;
    issue(12'h9C1, 12'h1C9);

    // start held high: one acceptance every CHUNKS+2 cycles
    repeat (3 * (CHUNKS + 2)) drive(1'b1, 12'($urandom), 12'($urandom));

    // Random traffic, biased toward equal upper chunks and sign boundaries
    for (int i = 0; i < 400; i++) begin
      ra = 12'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 12'($urandom);
        1: rb = ra ^ 12'($urandom_range(0, 7));
        2: rb = ra;
        default: rb = ra ^ 12'h800;
      endcase
      drive(($urandom_range(0, 2) == 0), ra, rb);
    end

    repeat (CHUNKS + 4) drive(1'b0, 12'h000, 12'h000);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
